// File: rtl/nlfsr_pkg.sv
// Shared definitions for the NLFSR maximal-period checker.
// Optional feature macro: NLFSR_ABORT_EN (adds an abort input to the top).
package nlfsr_pkg;

  // Encoding of the result output.
  typedef enum logic [1:0] {
    RES_FOUND   = 2'b00,
    RES_SHORT   = 2'b01,
    RES_TIMEOUT = 2'b10,
    RES_BADCFG  = 2'b11
  } result_t;

  // Test sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } fsm_state_t;

  // Maximal period of a SIZE-bit shift register: 2^SIZE - 1 (SIZE <= 63).
  function automatic logic [63:0] calc_period(input int unsigned size);
    return (64'd1 << size) - 64'd1;
  endfunction

endpackage

// File: rtl/nlfsr_feedback.sv
// Combinational NLFSR feedback: tap multiplexers followed by an AND/XOR term
// builder. Consecutive taps joined by mask bits form one product term; the
// feedback is state[0] XOR all product terms. Illegal tap codes (>= SIZE)
// read as 0 here; rejecting them is the caller's job.
// Optional feature macro: NLFSR_ABORT_EN (not used in this file).
module nlfsr_feedback
  import nlfsr_pkg::*;
#(
  parameter int SIZE        = 24,
  parameter int NUM_OF_TAPS = 6,
  parameter int TAP_W       = 8
) (
  input  logic [SIZE-1:0]              state_i,
  input  logic [NUM_OF_TAPS*TAP_W-1:0] codes_i,
  input  logic [NUM_OF_TAPS-2:0]       mask_i,
  output logic                         feedback_o
);

  logic [NUM_OF_TAPS-1:0] tap_v;
  logic                   fb;
  logic                   prod;

  // Tap mux: code 0 selects constant 0, codes 1..SIZE-1 select state[code].
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    tap_v = '0;
    for (int j = 0; j < NUM_OF_TAPS; j++) begin
      for (int b = 1; b < SIZE; b++) begin
        if (int'(codes_i[j*TAP_W +: TAP_W]) == b) tap_v[j] = state_i[b];
      end
    end
  end

  // Term builder: a running product is folded into the XOR sum whenever the
  // chain of AND links breaks.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each loop iteration sees
    // the value written by the previous one; registers use '<=' instead.
    fb   = state_i[0];
    prod = tap_v[0];
    for (int k = 1; k < NUM_OF_TAPS; k++) begin
      if (mask_i[k-1]) begin
        prod = prod & tap_v[k];
      end else begin
        fb   = fb ^ prod;
        prod = tap_v[k];
      end
    end
    fb = fb ^ prod;
  end

  assign feedback_o = fb;

endmodule

// File: rtl/nlfsr_period_checker.sv
// NLFSR maximal-period checker. On start the tap configuration is latched,
// validated, and the register is run from INIT = 1 until it returns to INIT
// or the shift count passes PERIOD + 3.
// Optional feature macro: NLFSR_ABORT_EN adds an 'abort' input that ends a
// test in CHECK or RUN with TIMEOUT and the current shift count.
module nlfsr_period_checker
  import nlfsr_pkg::*;
#(
  parameter int SIZE        = 24,
  parameter int NUM_OF_TAPS = 6,
  parameter int TAP_W       = 8,
  parameter int CNT_W       = SIZE + 1
) (
  input  logic                         clk,
  input  logic                         res_n,
  input  logic                         start,
  input  logic [NUM_OF_TAPS*TAP_W-1:0] co_buf,
  input  logic [NUM_OF_TAPS-2:0]       and_mask,
`ifdef NLFSR_ABORT_EN
  input  logic                         abort,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   result,
  output logic [CNT_W-1:0]             period_cnt
);

  localparam logic [SIZE-1:0]  INIT        = SIZE'(1);
  localparam logic [CNT_W-1:0] PERIOD      = CNT_W'(calc_period(SIZE));
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = PERIOD + CNT_W'(3);

  fsm_state_t                   fsm_q, fsm_d;
  logic [SIZE-1:0]              lfsr_q, lfsr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_OF_TAPS*TAP_W-1:0] codes_q, codes_d;
  logic [NUM_OF_TAPS-2:0]       mask_q, mask_d;
  result_t                      result_q, result_d;
  logic [CNT_W-1:0]             period_cnt_q, period_cnt_d;

  logic feedback;
  logic bad_cfg;
  logic abort_req;

`ifdef NLFSR_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  nlfsr_feedback #(
    .SIZE        (SIZE),
    .NUM_OF_TAPS (NUM_OF_TAPS),
    .TAP_W       (TAP_W)
  ) u_feedback (
    .state_i    (lfsr_q),
    .codes_i    (codes_q),
    .mask_i     (mask_q),
    .feedback_o (feedback)
  );

  // Any latched tap code at or above SIZE makes the configuration invalid.
  always_comb begin
    bad_cfg = 1'b0;
    for (int j = 0; j < NUM_OF_TAPS; j++) begin
      if (int'(codes_q[j*TAP_W +: TAP_W]) >= SIZE) bad_cfg = 1'b1;
    end
  end

  // Next-state logic: configuration latch, validation, shifting, termination.
  always_comb begin
    fsm_d        = fsm_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    codes_d      = codes_q;
    mask_d       = mask_q;
    result_d     = result_q;
    period_cnt_d = period_cnt_q;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          codes_d = co_buf;
          mask_d  = and_mask;
          cnt_d   = '0;
          fsm_d   = CHECK;
        end
      end

      CHECK: begin
        if (abort_req) begin
          result_d     = RES_TIMEOUT;
          period_cnt_d = cnt_q;
          fsm_d        = DONE;
        end else if (bad_cfg) begin
          result_d     = RES_BADCFG;
          period_cnt_d = '0;
          fsm_d        = DONE;
        end else begin
          lfsr_d = INIT;
          cnt_d  = '0;
          fsm_d  = RUN;
        end
      end

      RUN: begin
        // Decisions look at the registered state/count before this shift.
        if (abort_req) begin
          result_d     = RES_TIMEOUT;
          period_cnt_d = cnt_q;
          fsm_d        = DONE;
        end else if (lfsr_q == INIT && cnt_q == PERIOD) begin
          result_d     = RES_FOUND;
          period_cnt_d = cnt_q;
          fsm_d        = DONE;
        end else if (lfsr_q == INIT && cnt_q != '0 && cnt_q < PERIOD) begin
          result_d     = RES_SHORT;
          period_cnt_d = cnt_q;
          fsm_d        = DONE;
        end else if (cnt_q == TIMEOUT_CNT && lfsr_q != INIT) begin
          result_d     = RES_TIMEOUT;
          period_cnt_d = cnt_q;
          fsm_d        = DONE;
        end else begin
          lfsr_d = {feedback, lfsr_q[SIZE-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // A start seen here is dropped; only IDLE accepts it.
        fsm_d = IDLE;
      end

      default: fsm_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge res_n) begin
    // NOTE: every register here is plain control/datapath state (no memory
    // arrays), so all of it is reset to a known value.
    if (!res_n) begin
      fsm_q        <= IDLE;
      lfsr_q       <= INIT;
      cnt_q        <= '0;
      codes_q      <= '0;
      mask_q       <= '0;
      result_q     <= RES_FOUND;
      period_cnt_q <= '0;
    end else begin
      fsm_q        <= fsm_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      codes_q      <= codes_d;
      mask_q       <= mask_d;
      result_q     <= result_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign busy       = (fsm_q == CHECK) || (fsm_q == RUN);
  assign done       = (fsm_q == DONE);
  assign result     = result_q;
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_nlfsr_period_checker.sv
// Directed bench for nlfsr_period_checker at SIZE=4 (PERIOD=15). With
// NLFSR_ABORT_EN defined, a second SIZE=8 instance exercises abort.
module tb_nlfsr_period_checker;
  import nlfsr_pkg::*;

  localparam int SIZE = 4;
  localparam int NT   = 6;
  localparam int TW   = 8;
  localparam int CW   = SIZE + 1;

  logic           clk = 1'b0;
  logic           res_n;
  logic           start;
  logic [NT*TW-1:0] co_buf;
  logic [NT-2:0]  and_mask;
  logic           busy;
  logic           done;
  logic [1:0]     result;
  logic [CW-1:0]  period_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef NLFSR_ABORT_EN
  localparam int CW8 = 9;
  logic           abort;
  logic           start8;
  logic           abort8;
  logic [NT*TW-1:0] co8;
  logic [NT-2:0]  mask8;
  logic           busy8;
  logic           done8;
  logic [1:0]     result8;
  logic [CW8-1:0] cnt8;
`endif

  nlfsr_period_checker #(
    .SIZE (SIZE), .NUM_OF_TAPS (NT), .TAP_W (TW), .CNT_W (CW)
  ) u_dut (
    .clk        (clk),
    .res_n      (res_n),
    .start      (start),
    .co_buf     (co_buf),
    .and_mask   (and_mask),
`ifdef NLFSR_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .result     (result),
    .period_cnt (period_cnt)
  );

`ifdef NLFSR_ABORT_EN
  nlfsr_period_checker #(
    .SIZE (8), .NUM_OF_TAPS (NT), .TAP_W (TW), .CNT_W (CW8)
  ) u_dut8 (
    .clk        (clk),
    .res_n      (res_n),
    .start      (start8),
    .co_buf     (co8),
    .and_mask   (mask8),
    .abort      (abort8),
    .busy       (busy8),
    .done       (done8),
    .result     (result8),
    .period_cnt (cnt8)
  );
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start with a configuration and wait (bounded) for done. Called at
  // 1 time unit after a rising edge; returns at the same phase.
  task automatic run_test(input string tag, input logic [NT*TW-1:0] cfg,
                          input logic [NT-2:0] mask, input int exp_cycles,
                          input logic [1:0] exp_res, input int exp_cnt);
    int n;
    co_buf   = cfg;
    and_mask = mask;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    check({tag, "_busy"}, busy, 1);
    while (!done && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_lat"}, n, exp_cycles);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_cnt"}, period_cnt, exp_cnt);
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  saw_done;
    res_n    = 1'b0;
    start    = 1'b0;
    co_buf   = '0;
    and_mask = '0;
`ifdef NLFSR_ABORT_EN
    abort  = 1'b0;
    start8 = 1'b0;
    abort8 = 1'b0;
    co8    = '0;
    mask8  = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cnt", period_cnt, 0);
    res_n = 1'b1;
    @(posedge clk);
    #1;

    // s0^s1: maximal, returns to INIT after 15 shifts.
    run_test("lin_max", 48'h0000_0000_0001, 5'b0, 18, RES_FOUND, 15);
    // s0^s2: sequence repeats after 6 shifts.
    run_test("short6", 48'h0000_0000_0002, 5'b0, 9, RES_SHORT, 6);
    // Code 5 >= SIZE is rejected in CHECK.
    run_test("badcfg5", 48'h0000_0000_0005, 5'b0, 2, RES_BADCFG, 0);
    // Code exactly SIZE in the last tap slice.
    run_test("bad_tap6", 48'h0400_0000_0001, 5'b0, 2, RES_BADCFG, 0);
    // Highest legal code SIZE-1: s0^s3, maximal.
    run_test("tap_max", 48'h0000_0000_0003, 5'b0, 18, RES_FOUND, 15);
    // s0^s1^s2 (separate terms): period 7.
    run_test("xor3", 48'h0000_0000_0201, 5'b0, 10, RES_SHORT, 7);
    // s0^(s1&s2): period 4.
    run_test("and12", 48'h0000_0000_0201, 5'b00001, 7, RES_SHORT, 4);

    // Reset in the middle of RUN, with cnt = 7.
    co_buf   = 48'h1;
    and_mask = '0;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 res_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_cnt", period_cnt, 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    res_n = 1'b1;
    @(posedge clk);
    #1;
    run_test("post_rst", 48'h0000_0000_0001, 5'b0, 18, RES_FOUND, 15);

    // Start mid-RUN with a bad config, then change co_buf: both ignored.
    co_buf = 48'h1;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    repeat (5) @(posedge clk);
    #1 n += 5;
    co_buf = 48'h5;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n++;
    co_buf = 48'h2;
    while (!done && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check("ign_lat", n, 18);
    check("ign_res", result, RES_FOUND);
    check("ign_cnt", period_cnt, 15);
    // Start during the DONE cycle is dropped as well.
    co_buf = 48'h5;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_start_busy", busy, 0);
    check("done_start_done", done, 0);
    @(posedge clk);
    #1 check("done_start_busy2", busy, 0);
    check("done_start_res", result, RES_FOUND);
    check("done_start_cnt", period_cnt, 15);

`ifdef NLFSR_ABORT_EN
    // Abort in IDLE is ignored.
    abort8 = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort8 = 1'b0;
    check("abort_idle_busy", busy8, 0);
    check("abort_idle_done", done8, 0);
    // SIZE=8 run aborted while cnt = 40.
    co8    = 48'h1;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (41) @(posedge clk);
    #1 abort8 = 1'b1;
    @(posedge clk);
    #1 abort8 = 1'b0;
    check("abort_done", done8, 1);
    check("abort_res", result8, RES_TIMEOUT);
    check("abort_cnt", cnt8, 40);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
